// File: rtl/cycle_sequencer.sv
// ---------------------------------------------------------------------------
// cycle_sequencer
//
// Multi-phase instruction sequencer. Each instruction is fetched from memory,
// decoded into an operator and two operand addresses, both operands are read,
// an external operator unit is invoked, and its result is written back to the
// second operand address. An operator equal to HALT_OP stops the sequencer.
// Every handshake wait is guarded by a reply timeout that ends in ERROR.
//
// Parameters
//   ADDR_W   address / PC width
//   WORD_W   memory word width (sign bit at WORD_W-1), >= 1+OP_W+2*ADDR_W
//   OP_W     operator field width
//   HALT_OP  operator value that stops the sequencer
//   TIMEOUT  maximum number of cycles a request waits for its reply
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, load_pc, start_addr begin/resume; optionally load the PC first
//   step_mode                  return to IDLE after each instruction
//   mem_addr, mem_read_pulse,  memory request side; a request stays high
//   mem_write_pulse, mem_wdata until mem_reply is sampled
//   mem_reply, mem_rdata       memory reply side
//   operate_pulse, op_code,    operator unit request and operands
//   opnd_a, opnd_b
//   operate_reply, op_result   operator unit reply
//   pulse                      phase number of the current state
//   pc, running, halted,       status
//   timeout_err
// ---------------------------------------------------------------------------
module cycle_sequencer #(
  parameter int                ADDR_W  = 12,
  parameter int                WORD_W  = 31,
  parameter int                OP_W    = 6,
  parameter logic [OP_W-1:0]   HALT_OP = '1,
  parameter int                TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_pc,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              step_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_pulse,
  output logic              mem_write_pulse,
  input  logic              mem_reply,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              operate_pulse,
  input  logic              operate_reply,
  input  logic [WORD_W-1:0] op_result,
  output logic [OP_W-1:0]   op_code,
  output logic [WORD_W-1:0] opnd_a,
  output logic [WORD_W-1:0] opnd_b,
  output logic [2:0]        pulse,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic              halted,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, READ_A, LOAD_A, READ_B, LOAD_B, OPERATE, WRITE, HALT, ERROR
  } state_t;

  state_t state, next_state;

  // The sign bit of an instruction word carries no field, so it is not kept.
  logic [WORD_W-2:0] instr;
  logic [ADDR_W-1:0] a1, a2;
  logic [WORD_W-1:0] rdata_q;
  logic [ADDR_W-1:0] addr_hold;
  logic [CNT_W-1:0]  wait_cnt;

  logic is_wait;
  logic timed_out;
  logic decoded_halt;

  assign is_wait      = (state == FETCH) || (state == READ_A) || (state == READ_B) ||
                        (state == OPERATE) || (state == WRITE);
  // Last cycle of the wait window; a reply in this same cycle still wins.
  assign timed_out    = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign decoded_halt = (instr[WORD_W-2 -: OP_W] == HALT_OP);

  // Next-state logic.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, HALT, ERROR: if (start) next_state = FETCH;
      FETCH: begin
        if (mem_reply)      next_state = DECODE;
        else if (timed_out) next_state = ERROR;
      end
      DECODE: next_state = decoded_halt ? HALT : READ_A;
      READ_A: begin
        if (mem_reply)      next_state = LOAD_A;
        else if (timed_out) next_state = ERROR;
      end
      LOAD_A: next_state = READ_B;
      READ_B: begin
        if (mem_reply)      next_state = LOAD_B;
        else if (timed_out) next_state = ERROR;
      end
      LOAD_B: next_state = OPERATE;
      OPERATE: begin
        if (operate_reply)  next_state = WRITE;
        else if (timed_out) next_state = ERROR;
      end
      WRITE: begin
        if (mem_reply)      next_state = step_mode ? IDLE : FETCH;
        else if (timed_out) next_state = ERROR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Requests and status decode straight from the state register, so the
  // asynchronous reset drops them in the same cycle it is asserted.
  always_comb begin
    mem_read_pulse  = (state == FETCH) || (state == READ_A) || (state == READ_B);
    mem_write_pulse = (state == WRITE);
    operate_pulse   = (state == OPERATE);
    running         = (state != IDLE) && (state != HALT) && (state != ERROR);
    halted          = (state == HALT);
    timeout_err     = (state == ERROR);

    pulse = 3'd0;
    unique case (state)
      FETCH:   pulse = 3'd1;
      DECODE:  pulse = 3'd2;
      READ_A:  pulse = 3'd3;
      LOAD_A:  pulse = 3'd4;
      READ_B:  pulse = 3'd5;
      LOAD_B:  pulse = 3'd6;
      OPERATE: pulse = 3'd7;
      default: pulse = 3'd0;
    endcase

    // Outside the request states the address keeps its last driven value.
    mem_addr = addr_hold;
    unique case (state)
      FETCH:         mem_addr = pc;
      READ_A:        mem_addr = a1;
      READ_B, WRITE: mem_addr = a2;
      default:       mem_addr = addr_hold;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= '0;
      instr     <= '0;
      a1        <= '0;
      a2        <= '0;
      op_code   <= '0;
      rdata_q   <= '0;
      opnd_a    <= '0;
      opnd_b    <= '0;
      mem_wdata <= '0;
      addr_hold <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= next_state;
      addr_hold <= mem_addr;

      // The reply counter restarts on every state change and only advances
      // while a request is outstanding.
      if (next_state != state) wait_cnt <= '0;
      else if (is_wait)        wait_cnt <= wait_cnt + 1'b1;

      unique case (state)
        IDLE, HALT, ERROR: if (start && load_pc) pc <= start_addr;
        FETCH:   if (mem_reply) instr <= mem_rdata[WORD_W-2:0];
        DECODE: begin
          op_code <= instr[WORD_W-2 -: OP_W];
          a1      <= instr[2*ADDR_W-1:ADDR_W];
          a2      <= instr[ADDR_W-1:0];
          pc      <= pc + 1'b1;
        end
        READ_A, READ_B: if (mem_reply) rdata_q <= mem_rdata;
        LOAD_A:  opnd_a <= rdata_q;
        LOAD_B:  opnd_b <= rdata_q;
        OPERATE: if (operate_reply) mem_wdata <= op_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cycle_sequencer
//
// Bench for cycle_sequencer. A memory model and an operator-unit model reply
// to requests after programmable delays and log every transfer. A table of
// single-instruction programs run in step mode is checked against hand
// computed expectations, followed by directed sequences for timeout,
// continuous run with PC wrap, halt/resume, and reset during OPERATE.
// ---------------------------------------------------------------------------
module tb_cycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        load_pc;
  logic [11:0] start_addr;
  logic        step_mode;
  logic [11:0] mem_addr;
  logic        mem_read_pulse;
  logic        mem_write_pulse;
  logic        mem_reply;
  logic [30:0] mem_rdata;
  logic [30:0] mem_wdata;
  logic        operate_pulse;
  logic        operate_reply;
  logic [30:0] op_result;
  logic [5:0]  op_code;
  logic [30:0] opnd_a;
  logic [30:0] opnd_b;
  logic [2:0]  pulse;
  logic [11:0] pc;
  logic        running;
  logic        halted;
  logic        timeout_err;

  cycle_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .load_pc(load_pc), .start_addr(start_addr), .step_mode(step_mode),
    .mem_addr(mem_addr), .mem_read_pulse(mem_read_pulse), .mem_write_pulse(mem_write_pulse),
    .mem_reply(mem_reply), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .operate_pulse(operate_pulse), .operate_reply(operate_reply), .op_result(op_result),
    .op_code(op_code), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .pulse(pulse), .pc(pc), .running(running), .halted(halted), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- responder / monitor models ----------------
  logic [30:0] mem [0:4095];
  int          mem_delay, rb_delay, op_delay;
  logic [30:0] result_val;
  logic        force_op_reply;

  int          m_cnt, o_cnt;
  logic [11:0] reads[$];
  logic [11:0] fetches[$];
  int          n_writes;
  logic [11:0] w_addr;
  logic [30:0] w_data;
  int          op_len, rb_len, multi_req_err;
  logic [31:0] seq;
  logic [3:0]  last_p;

  task automatic clear_logs();
    reads.delete();
    fetches.delete();
    n_writes = 0;
    w_addr   = '0;
    w_data   = '0;
    op_len   = 0;
    rb_len   = 0;
    seq      = '0;
    last_p   = 4'hF;
  endtask

  always @(negedge clk) begin
    int  d;
    logic op_rep;
    if (mem_reply)     m_cnt = 0;
    if (operate_reply) o_cnt = 0;

    // Phase trace, one entry per change of pulse while running.
    if (running && ({1'b0, pulse} != last_p)) begin
      seq    = {seq[27:0], 1'b0, pulse};
      last_p = {1'b0, pulse};
    end
    if (pulse == 3'd5) rb_len++;
    if (operate_pulse) op_len++;
    if (int'(mem_read_pulse) + int'(mem_write_pulse) + int'(operate_pulse) > 1) multi_req_err++;

    if (mem_read_pulse || mem_write_pulse) begin
      m_cnt++;
      d = (pulse == 3'd5) ? rb_delay : mem_delay;
      if (m_cnt > d) begin
        mem_reply = 1'b1;
        if (mem_read_pulse) begin
          mem_rdata = mem[mem_addr];
          reads.push_back(mem_addr);
          if (pulse == 3'd1) fetches.push_back(mem_addr);
        end else begin
          mem[mem_addr] = mem_wdata;
          n_writes++;
          w_addr = mem_addr;
          w_data = mem_wdata;
        end
      end else begin
        mem_reply = 1'b0;
      end
    end else begin
      m_cnt     = 0;
      mem_reply = 1'b0;
    end

    op_rep = 1'b0;
    if (operate_pulse) begin
      o_cnt++;
      if (o_cnt > op_delay) begin
        op_rep    = 1'b1;
        op_result = result_val;
      end
    end else begin
      o_cnt = 0;
    end
    operate_reply = op_rep | force_op_reply;
  end

  // ---------------- helpers ----------------
  task automatic run_prog(input string name, input logic [11:0] sa, input logic ld,
                          input logic step, input bit poke);
    bit done;
    @(negedge clk);
    clear_logs();
    start = 1'b1; load_pc = ld; start_addr = sa; step_mode = step;
    @(negedge clk);
    start = 1'b0; load_pc = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!running) begin
        done = 1'b1;
        break;
      end
      // A start while running must be ignored, even with a new address.
      if (poke && i == 5) begin
        start = 1'b1; load_pc = 1'b1; start_addr = 12'o0300;
      end else if (poke && i == 6) begin
        start = 1'b0; load_pc = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; load_pc = 1'b0;
    check({name, "_stopped"}, 64'(done), 64'(1));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},      64'(pc), 0);
    check({tag, "_pulse"},   64'(pulse), 0);
    check({tag, "_op_code"}, 64'(op_code), 0);
    check({tag, "_opnd_a"},  64'(opnd_a), 0);
    check({tag, "_opnd_b"},  64'(opnd_b), 0);
    check({tag, "_wdata"},   64'(mem_wdata), 0);
    check({tag, "_addr"},    64'(mem_addr), 0);
    check({tag, "_running"}, 64'(running), 0);
    check({tag, "_halted"},  64'(halted), 0);
    check({tag, "_tmo"},     64'(timeout_err), 0);
    check({tag, "_reqs"},    64'({mem_read_pulse, mem_write_pulse, operate_pulse}), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [11:0] sa;
    logic [30:0] instr;
    logic [30:0] val_a;
    logic [30:0] val_b;
    logic [30:0] result;
    int          mdly;
    int          odly;
    logic [5:0]  exp_op;
    logic        exp_halt;
    logic [11:0] exp_pc;
    int          exp_reads;
    int          exp_op_len;
    logic [11:0] exp_a1;
    logic [11:0] exp_waddr;
    logic [31:0] exp_seq;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; load_pc = 1'b0; start_addr = '0; step_mode = 1'b1;
    mem_reply = 1'b0; mem_rdata = '0; operate_reply = 1'b0; op_result = '0;
    mem_delay = 0; rb_delay = 0; op_delay = 0; result_val = '0; force_op_reply = 1'b0;
    m_cnt = 0; o_cnt = 0; multi_req_err = 0;
    clear_logs();
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    //          name       sa        instr            val_a          val_b          result           mdly odly op     halt pc        rd oplen a1        waddr     seq
    vecs[0] = '{"basic",   12'o0001, 31'o0011112222, 31'h1234_5678, 31'h0765_4321, 31'o4444444444, 0,   5,   6'o00, 0,   12'o0002, 3, 6,    12'o1111, 12'o2222, 32'h1234_5670};
    vecs[1] = '{"slowmem", 12'o0500, 31'o1201000200, 31'h4000_0001, 31'h7fff_ffff, 31'h5555_aaaa, 3,   0,   6'o12, 0,   12'o0501, 3, 1,    12'o0100, 12'o0200, 32'h1234_5670};
    vecs[2] = '{"halt",    12'o0700, 31'o7700000000, 31'h0,         31'h0,         31'h0,         0,   0,   6'o77, 1,   12'o0701, 1, 0,    12'o0000, 12'o0000, 32'h0000_0012};
    vecs[3] = '{"wrapstep",12'o7777, 31'o0100037776, 31'h0,         31'h0000_0001, 31'h0,         1,   2,   6'o01, 0,   12'o0000, 3, 3,    12'o0003, 12'o7776, 32'h1234_5670};

    // Reset values, then release.
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("idle");

    // Table of single-instruction programs in step mode.
    foreach (vecs[k]) begin
      mem_delay  = vecs[k].mdly;
      rb_delay   = vecs[k].mdly;
      op_delay   = vecs[k].odly;
      result_val = vecs[k].result;
      mem[vecs[k].sa] = vecs[k].instr;
      if (!vecs[k].exp_halt) begin
        mem[vecs[k].exp_a1]    = vecs[k].val_a;
        mem[vecs[k].exp_waddr] = vecs[k].val_b;
      end
      run_prog(vecs[k].name, vecs[k].sa, 1'b1, 1'b1, 1'b0);
      check({vecs[k].name, "_seq"},    64'(seq), 64'(vecs[k].exp_seq));
      check({vecs[k].name, "_pc"},     64'(pc), 64'(vecs[k].exp_pc));
      check({vecs[k].name, "_halted"}, 64'(halted), 64'(vecs[k].exp_halt));
      check({vecs[k].name, "_op"},     64'(op_code), 64'(vecs[k].exp_op));
      check({vecs[k].name, "_nreads"}, 64'(reads.size()), 64'(vecs[k].exp_reads));
      check({vecs[k].name, "_oplen"},  64'(op_len), 64'(vecs[k].exp_op_len));
      check({vecs[k].name, "_fetch"},  64'(fetches.size() > 0 ? fetches[0] : 12'hfff), 64'(vecs[k].sa));
      if (vecs[k].exp_halt) begin
        check({vecs[k].name, "_nwrites"}, 64'(n_writes), 0);
      end else begin
        check({vecs[k].name, "_nwrites"}, 64'(n_writes), 1);
        check({vecs[k].name, "_rd_a1"},   64'(reads.size() > 1 ? reads[1] : 12'hfff), 64'(vecs[k].exp_a1));
        check({vecs[k].name, "_rd_a2"},   64'(reads.size() > 2 ? reads[2] : 12'hfff), 64'(vecs[k].exp_waddr));
        check({vecs[k].name, "_opnd_a"},  64'(opnd_a), 64'(vecs[k].val_a));
        check({vecs[k].name, "_opnd_b"},  64'(opnd_b), 64'(vecs[k].val_b));
        check({vecs[k].name, "_wdata"},   64'(mem_wdata), 64'(vecs[k].result));
        check({vecs[k].name, "_waddr"},   64'(w_addr), 64'(vecs[k].exp_waddr));
        check({vecs[k].name, "_wdat"},    64'(w_data), 64'(vecs[k].result));
      end
    end

    // Continuous run from 7777: wraps to 0000, halts at 0001; a start while
    // running is ignored.
    mem[12'o7777] = 31'o0101000200;
    mem[12'o0000] = 31'o0201010201;
    mem[12'o0001] = 31'o7700000000;
    mem[12'o0002] = 31'o7700000000;
    mem_delay = 2; rb_delay = 2; op_delay = 1; result_val = 31'h0abc_def0;
    run_prog("cont", 12'o7777, 1'b1, 1'b0, 1'b1);
    check("cont_nfetch",  64'(fetches.size()), 3);
    check("cont_fetch0",  64'(fetches.size() > 0 ? fetches[0] : 12'h0aa), 64'(12'o7777));
    check("cont_fetch1",  64'(fetches.size() > 1 ? fetches[1] : 12'h0aa), 64'(12'o0000));
    check("cont_fetch2",  64'(fetches.size() > 2 ? fetches[2] : 12'h0aa), 64'(12'o0001));
    check("cont_halted",  64'(halted), 1);
    check("cont_pc",      64'(pc), 64'(12'o0002));
    check("cont_nwrites", 64'(n_writes), 2);

    // Resume from HALT without loading the PC.
    run_prog("resume", 12'o0000, 1'b0, 1'b0, 1'b0);
    check("resume_fetch", 64'(fetches.size() > 0 ? fetches[0] : 12'h0aa), 64'(12'o0002));
    check("resume_halt",  64'(halted), 1);
    check("resume_pc",    64'(pc), 64'(12'o0003));

    // Reply withheld in READ_B: timeout after 64 cycles.
    mem[12'o0010] = 31'o0000200030;
    mem_delay = 0; op_delay = 0; rb_delay = 1000; result_val = 31'h0000_0777;
    run_prog("tmo", 12'o0010, 1'b1, 1'b1, 1'b0);
    check("tmo_err",     64'(timeout_err), 1);
    check("tmo_rb_len",  64'(rb_len), 64);
    check("tmo_reqs",    64'({mem_read_pulse, mem_write_pulse, operate_pulse}), 0);
    check("tmo_pulse",   64'(pulse), 0);
    check("tmo_nwrites", 64'(n_writes), 0);
    check("tmo_halted",  64'(halted), 0);

    // Reply in the 64th cycle still counts as success.
    rb_delay = 63;
    run_prog("edge", 12'o0010, 1'b1, 1'b1, 1'b0);
    check("edge_err",     64'(timeout_err), 0);
    check("edge_rb_len",  64'(rb_len), 64);
    check("edge_nwrites", 64'(n_writes), 1);
    check("edge_wdat",    64'(w_data), 64'(31'h0000_0777));
    check("edge_pc",      64'(pc), 64'(12'o0011));

    // Reset asserted in the middle of OPERATE.
    mem[12'o0040] = 31'o0500500060;
    rb_delay = 0; op_delay = 1000;
    @(negedge clk);
    clear_logs();
    start = 1'b1; load_pc = 1'b1; start_addr = 12'o0040; step_mode = 1'b1;
    @(negedge clk);
    start = 1'b0; load_pc = 1'b0;
    begin : wait_op
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (operate_pulse) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("rstop_reached", 64'(seen), 1);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("rstop");
    op_delay = 0;
    force_op_reply = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_pulse", 64'(pulse), 0);
    check("stray_run",   64'(running), 0);
    check("stray_reqs",  64'({mem_read_pulse, mem_write_pulse, operate_pulse}), 0);
    check("stray_wdata", 64'(mem_wdata), 0);
    force_op_reply = 1'b0;
    @(negedge clk);

    check("one_request", 64'(multi_req_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
